// File: rtl/video_mem_arbiter.sv
// video_mem_arbiter
// Time-slices one single-port video/CPU RAM between the video controller's
// pixel/roller fetches and Z80 CPU accesses. Each pixel is four clk_sys
// cycles, numbered ph=0..3 from the ce_pix cycle:
//   ph=1  video slot: RAM address = vid_addr
//   ph=2  vid_din captures the RAM read data
//   ph=3  CPU slot:   RAM address/we/wdata from the CPU request
//   ph=0  cpu_ack for an access issued at ph=3
// Optional feature macro: BLANK_CPU_SLOT_EN. When it is defined and vid_blank
// is high, ph=1 becomes a second CPU slot (ack at ph=2) and vid_din is frozen.
//
// Ports
//   clk_sys, reset        64 MHz clock, synchronous active-high reset
//   ce_pix                pixel strobe, 1 cycle in 4; forces ph=0
//   vid_addr, vid_blank   video read address and vertical blank
//   vid_din               video read data, held between updates
//   cpu_req/we/addr/wdata CPU request (level) and its qualifiers
//   cpu_rdata, cpu_ack    CPU read data and 1-cycle completion pulse
//   mem_addr/we/wdata     RAM command, driven only in a live slot (else 0)
//   mem_rdata             RAM read data, one cycle after the address
//   dbg_ph                current slot phase
//
// CPU handshake: cpu_req is a level held with stable cpu_we/addr/wdata until
// the CPU sees cpu_ack. An access issues only in a CPU slot while no ack is
// showing; cpu_ack pulses for exactly one cycle the cycle after issue, and
// read data is valid in that same cycle. A request still high after the ack
// cycle is a new request and waits for the next CPU slot. A request dropped
// before its slot issues nothing.

module video_mem_arbiter #(
    parameter int AW = 17,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [AW-1:0] vid_addr,
    input  logic          vid_blank,
    output logic [DW-1:0] vid_din,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_ph
);

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } ph_t;

    ph_t           ph_q;
    ph_t           ph_cur;
    ph_t           ph_next;
    logic          from_ph2_q;   // previous cycle was ph=2, so this ph=3 is live
    logic          cpu_ack_q;
    logic          ack_rd_q;     // the ack now showing belongs to a read
    logic [DW-1:0] vid_din_q;
    logic [DW-1:0] cpu_rdata_q;
    logic          blank_cpu;
    logic          vid_slot;
    logic          cpu_slot;
    logic          cpu_issue;
    logic          vid_load;
    logic          rd_ack;

`ifdef BLANK_CPU_SLOT_EN
    assign blank_cpu = vid_blank;
`else
    logic unused_vid_blank;
    assign blank_cpu        = 1'b0;
    assign unused_vid_blank = vid_blank;
`endif

    // Phase: ce_pix resyncs to 0 in its own cycle; without it the count
    // stops at 3 and no further slot opens until the next ce_pix.
    always_comb begin
        ph_cur  = ce_pix ? PH_0 : ph_q;
        ph_next = PH_3;
        case (ph_cur)
            PH_0:    ph_next = PH_1;
            PH_1:    ph_next = PH_2;
            PH_2:    ph_next = PH_3;
            default: ph_next = PH_3;
        endcase
    end

    always_comb begin
        vid_slot  = !reset && (ph_cur == PH_1) && !blank_cpu;
        cpu_slot  = !reset && !cpu_ack_q &&
                    (((ph_cur == PH_3) && from_ph2_q) ||
                     ((ph_cur == PH_1) && blank_cpu));
        cpu_issue = cpu_slot && cpu_req;
        vid_load  = !reset && (ph_cur == PH_2) && !blank_cpu;
        rd_ack    = !reset && cpu_ack_q && ack_rd_q;

        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (vid_slot) begin
            mem_addr = vid_addr;
        end else if (cpu_issue) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ph_q        <= PH_3;
            from_ph2_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ack_rd_q    <= 1'b0;
            vid_din_q   <= '0;
            cpu_rdata_q <= '0;
        end else begin
            ph_q       <= ph_next;
            from_ph2_q <= (ph_cur == PH_2);
            cpu_ack_q  <= cpu_issue;
            ack_rd_q   <= cpu_issue && !cpu_we;
            if (vid_load) begin
                vid_din_q <= mem_rdata;
            end
            if (rd_ack) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data passes straight through in the ack cycle, then is held.
    assign cpu_rdata = rd_ack ? mem_rdata : cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q && !reset;
    assign vid_din   = vid_din_q;
    assign dbg_ph    = ph_cur;

endmodule

// File: tb/tb_video_mem_arbiter.sv
module tb_video_mem_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;

  // clock / reset
  logic clk_sys = 1'b0;
  always #8 clk_sys = ~clk_sys;

  logic          reset;
  logic          ce_pix;
  logic [AW-1:0] vid_addr;
  logic          vid_blank;
  logic [DW-1:0] vid_din;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_ph;

  video_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .vid_addr(vid_addr), .vid_blank(vid_blank), .vid_din(vid_din),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_ph(dbg_ph)
  );

  // RAM model: registered read (old data on same-cycle write), preload port
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk_sys) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver: staged inputs applied at the falling edge
  logic          s_reset = 1'b1;
  logic          s_req = 1'b0, s_we = 1'b0, s_blank = 1'b0;
  logic [AW-1:0] s_addr = '0, s_vaddr = '0;
  logic [DW-1:0] s_wdata = '0;

  task automatic clk(input logic ce);
    @(negedge clk_sys);
    ce_pix = ce; reset = s_reset; cpu_req = s_req; cpu_we = s_we;
    cpu_addr = s_addr; cpu_wdata = s_wdata; vid_addr = s_vaddr; vid_blank = s_blank;
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    clk(1'b0);
    pl_en = 1'b0;
  endtask

  // run n pixels plus one ce cycle, counting acks and checking read data
  task automatic run_count(input int n_pix, output int acks, output int b2b);
    logic prev;
    prev = 1'b0; acks = 0; b2b = 0;
    for (int c = 0; c < n_pix * 4 + 1; c++) begin
      clk(c % 4 == 0);
      if (cpu_ack) begin
        acks++;
        if (prev) b2b++;
        if (exp_q.size() == 0) check("extra_ack", 32'd1, 32'd0);
        else check("ack_rdata", cpu_rdata, exp_q.pop_front());
      end
      prev = cpu_ack;
    end
  endtask

  int acks, b2b, exp_acks;
  logic [DW-1:0] exp_vid;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ce_pix = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; vid_addr = '0; vid_blank = 1'b0;

    // reset state, with RAM preload done while the arbiter is held
    poke(17'h01234, 8'hA5);
    poke(17'h00100, 8'hFF);
    clk(1'b0);
    check("rst_vid_din", vid_din, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ph", dbg_ph, 3);

    // saturated phase after reset: a request must not issue
    s_reset = 1'b0; s_req = 1'b1; s_we = 1'b1; s_addr = 17'h00055; s_wdata = 8'h77;
    clk(1'b0);
    clk(1'b0);
    check("sat_mem_we", mem_we, 0);
    check("sat_mem_addr", mem_addr, 0);
    s_req = 1'b0;
    clk(1'b0);
    check("sat_no_ack", cpu_ack, 0);

    // video read
    s_vaddr = 17'h01234;
    clk(1'b1); check("vid_ph0", dbg_ph, 0);
    clk(1'b0); check("vid_ph1_addr", mem_addr, 32'h01234); check("vid_ph1_we", mem_we, 0);
    clk(1'b0); check("vid_ph2_ph", dbg_ph, 2);
    clk(1'b0); check("vid_ph3_din", vid_din, 32'hA5);
    clk(1'b0); check("vid_hold_din", vid_din, 32'hA5); check("vid_idle_addr", mem_addr, 0);

    // CPU write 0x5A to 0x1FFFF
    s_req = 1'b1; s_we = 1'b1; s_addr = 17'h1FFFF; s_wdata = 8'h5A;
    clk(1'b1); check("wr_ph0_we", mem_we, 0);
    clk(1'b0); check("wr_ph1_we", mem_we, 0);
    clk(1'b0); check("wr_ph2_we", mem_we, 0);
    clk(1'b0); check("wr_ph3_we", mem_we, 1); check("wr_ph3_addr", mem_addr, 32'h1FFFF);
    check("wr_ph3_wdata", mem_wdata, 32'h5A); check("wr_ph3_noack", cpu_ack, 0);
    clk(1'b1); check("wr_ack", cpu_ack, 1); check("wr_ack_we", mem_we, 0);

    // CPU read back
    s_we = 1'b0;
    clk(1'b0); check("rd_ph1_ack", cpu_ack, 0);
    clk(1'b0);
    clk(1'b0); check("rd_ph3_addr", mem_addr, 32'h1FFFF); check("rd_ph3_we", mem_we, 0);
    clk(1'b1); check("rd_ack", cpu_ack, 1); check("rd_rdata", cpu_rdata, 32'h5A);
    s_req = 1'b0;
    clk(1'b0); check("rd_ack_gone", cpu_ack, 0); check("rd_rdata_hold", cpu_rdata, 32'h5A);
    clk(1'b0);
    clk(1'b0); check("rd_dropped_no_issue", mem_addr, 0);

    // same-pixel conflict: video sees old 0xFF, next pixel sees 0x00
    s_vaddr = 17'h00100;
    s_req = 1'b1; s_we = 1'b1; s_addr = 17'h00100; s_wdata = 8'h00;
    clk(1'b1);
    clk(1'b0);
    clk(1'b0);
    clk(1'b0); check("cf_old_byte", vid_din, 32'hFF); check("cf_we", mem_we, 1);
    clk(1'b1); check("cf_ack", cpu_ack, 1);
    s_req = 1'b0;
    clk(1'b0);
    clk(1'b0);
    clk(1'b0); check("cf_new_byte", vid_din, 32'h00);

    // request held for 3 pixels: 3 acks, never back-to-back
    s_vaddr = 17'h01234;
    s_req = 1'b1; s_we = 1'b0; s_addr = 17'h01234;
    repeat (3) exp_q.push_back(8'hA5);
    run_count(3, acks, b2b);
    check("held_acks", acks, 3);
    check("held_b2b", b2b, 0);
    s_req = 1'b0;
    clk(1'b0);
    clk(1'b0);
    clk(1'b0);

    // reset at ph=3 with a read issuing: no ack, outputs cleared
    s_req = 1'b1; s_we = 1'b0; s_addr = 17'h01234;
    clk(1'b1);
    clk(1'b0);
    clk(1'b0);
    s_reset = 1'b1;
    clk(1'b0);
    check("mr_ph3_addr", mem_addr, 0); check("mr_ph3_we", mem_we, 0);
    check("mr_ph3_ack", cpu_ack, 0);
    clk(1'b0);
    check("mr_ack", cpu_ack, 0); check("mr_vid_din", vid_din, 0);
    check("mr_rdata", cpu_rdata, 0); check("mr_ph", dbg_ph, 3);
    s_reset = 1'b0;
    clk(1'b0); check("mr_post_ack0", cpu_ack, 0);
    clk(1'b0); check("mr_post_ack1", cpu_ack, 0);
    clk(1'b1); check("mr_post_ack2", cpu_ack, 0);
    clk(1'b0);
    clk(1'b0);
    clk(1'b0);
    exp_q.push_back(8'hA5);
    clk(1'b1); check("mr_req_ack", cpu_ack, 1);
    if (exp_q.size() != 0) check("mr_req_rdata", cpu_rdata, exp_q.pop_front());

    // vertical blank with request held
    s_blank = 1'b1; s_vaddr = 17'h00100; s_addr = 17'h1FFFF;
`ifdef BLANK_CPU_SLOT_EN
    exp_acks = 4; exp_vid = 8'hA5;
`else
    exp_acks = 2; exp_vid = 8'h00;
`endif
    repeat (exp_acks) exp_q.push_back(8'h5A);
    run_count(2, acks, b2b);
    check("blank_acks", acks, exp_acks);
    check("blank_b2b", b2b, 0);
    check("blank_vid_din", vid_din, exp_vid);
    check("blank_q_empty", exp_q.size(), 0);
    s_req = 1'b0; s_blank = 1'b0;
    clk(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
